// File: rtl/lcd_byte_writer.sv
// LCD byte writer: runs the 4-bit power-on init, then sends handshaked bytes
// as two timed nibbles (setup, enable pulse, hold, settle) on the LCD pins.
module lcd_byte_writer #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_NIB   = 50,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic       d,
    output logic       c,
    output logic       b,
    output logic       a
);

    typedef enum logic [2:0] {
        S_PWR,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // A phase of T cycles loads T-1 and ends on the edge where the counter is 0.
    function automatic logic [19:0] load_val(input int unsigned t);
        load_val = (t == 0) ? 20'd0 : 20'(t - 1);
    endfunction

    localparam logic [19:0] LD_SETUP = load_val(T_SETUP);
    localparam logic [19:0] LD_PULSE = load_val(T_PULSE);
    localparam logic [19:0] LD_HOLD  = load_val(T_HOLD);
    localparam logic [19:0] LD_NIB   = load_val(T_NIB);
    localparam logic [19:0] LD_CMD   = load_val(T_CMD);
    localparam logic [19:0] LD_CLR   = load_val(T_CLR);
    localparam logic [19:0] LD_PWR   = load_val(T_PWR);
    localparam logic [19:0] LD_INIT1 = load_val(T_INIT1);
    localparam logic [19:0] LD_INIT2 = load_val(T_INIT2);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        in_init_q, in_init_d;
    logic [1:0]  idx_q, idx_d;
    logic        lo_q, lo_d;
    logic [7:0]  byte_q, byte_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [3:0]  nib_q, nib_d;
    logic        wr_ready_q, wr_ready_d;
    logic        init_done_q, init_done_d;

    logic        expired;
    logic [19:0] post_wait;

    assign expired = (cnt_q == 20'd0);

    always_comb begin
        post_wait = LD_CMD;
        if (in_init_q) begin
            case (idx_q)
                2'd0:    post_wait = LD_INIT1;
                2'd1:    post_wait = LD_INIT2;
                default: post_wait = LD_CMD;
            endcase
        end else if (!lo_q) begin
            post_wait = LD_NIB;
        end else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) begin
            post_wait = LD_CLR;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = expired ? cnt_q : cnt_q - 20'd1;
        in_init_d   = in_init_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        nib_d       = nib_q;
        init_done_d = init_done_q;

        case (state_q)
            S_PWR: begin
                if (expired) begin
                    state_d   = S_SETUP;
                    cnt_d     = LD_SETUP;
                    in_init_d = 1'b1;
                    idx_d     = 2'd0;
                    rs_d      = 1'b0;
                    nib_d     = 4'h3;
                end
            end
            S_IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    byte_d  = wr_data;
                    lo_d    = 1'b0;
                    rs_d    = wr_rs;
                    nib_d   = wr_data[7:4];
                end
            end
            S_SETUP: begin
                if (expired) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end
            end
            S_PULSE: begin
                if (expired) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (expired) begin
                    state_d = S_WAIT;
                    cnt_d   = post_wait;
                end
            end
            S_WAIT: begin
                if (expired) begin
                    if (in_init_q) begin
                        if (idx_q == 2'd3) begin
                            state_d     = S_IDLE;
                            in_init_d   = 1'b0;
                            init_done_d = 1'b1;
                        end else begin
                            state_d = S_SETUP;
                            cnt_d   = LD_SETUP;
                            idx_d   = idx_q + 2'd1;
                            nib_d   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                        end
                    end else if (!lo_q) begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        lo_d    = 1'b1;
                        nib_d   = byte_q[3:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_PWR;
        endcase

        // Outputs are registered from the next state so they track it exactly.
        e_d        = (state_d == S_PULSE);
        wr_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWR;
            cnt_q       <= LD_PWR;
            in_init_q   <= 1'b1;
            idx_q       <= 2'd0;
            lo_q        <= 1'b0;
            byte_q      <= 8'h00;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            nib_q       <= 4'h0;
            wr_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_init_q   <= in_init_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            byte_q      <= byte_d;
            e_q         <= e_d;
            rs_q        <= rs_d;
            nib_q       <= nib_d;
            wr_ready_q  <= wr_ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign sf_e      = 1'b1;
    assign rw        = 1'b0;
    assign e         = e_q;
    assign rs        = rs_q;
    assign d         = nib_q[3];
    assign c         = nib_q[2];
    assign b         = nib_q[1];
    assign a         = nib_q[0];
    assign wr_ready  = wr_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: directed and random bytes checked
// against expected pulse lists and occupancy derived from the timing rules.
module tb_lcd_byte_writer;

    localparam int TS  = 2;
    localparam int TP  = 3;
    localparam int TH  = 1;
    localparam int TN  = 4;
    localparam int TC  = 8;
    localparam int TCL = 20;
    localparam int TPW = 10;
    localparam int TI1 = 6;
    localparam int TI2 = 5;
    localparam int INIT_LEN = TPW + 4 * (TS + TP + TH) + TI1 + TI2 + 2 * TC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, sf_e, e, rs, rw, d, c, b, a;

    lcd_byte_writer #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_NIB(TN), .T_CMD(TC),
        .T_CLR(TCL), .T_PWR(TPW), .T_INIT1(TI1), .T_INIT2(TI2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_rs(wr_rs),
        .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done),
        .sf_e(sf_e), .e(e), .rs(rs), .rw(rw), .d(d), .c(c), .b(b), .a(a)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse monitor, sampled on the falling edge.
    int         ncnt = 0;
    logic       e_prev = 1'b0;
    logic [4:0] prev_rsn = 5'd0;
    int         stable = 0;
    int         bad_const = 0;
    int         bad_stab = 0;
    int         bad_setup = 0;
    int         p_rise[$];
    int         p_fall[$];
    logic [3:0] p_nib[$];
    logic       p_rs[$];

    always @(negedge clk) begin
        ncnt++;
        if (sf_e !== 1'b1 || rw !== 1'b0) bad_const++;
        if ({rs, d, c, b, a} !== prev_rsn) begin
            if (e && e_prev) bad_stab++;
            stable = 0;
        end else begin
            stable++;
        end
        if (e === 1'b1 && e_prev !== 1'b1) begin
            p_rise.push_back(ncnt);
            p_nib.push_back({d, c, b, a});
            p_rs.push_back(rs);
            if (stable < TS) bad_setup++;
        end
        if (e !== 1'b1 && e_prev === 1'b1) p_fall.push_back(ncnt);
        prev_rsn = {rs, d, c, b, a};
        e_prev   = e;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Expected pulse list built by the model.
    logic [3:0] ex_nib[$];
    logic       ex_rs[$];

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int occupancy(input logic r, input logic [7:0] dat);
        return 2 * (TS + TP + TH) + TN + ((!r && (dat == 8'h01 || dat == 8'h02)) ? TCL : TC);
    endfunction

    task automatic expect_byte(input logic r, input logic [7:0] dat);
        ex_rs.push_back(r);  ex_nib.push_back(dat[7:4]);
        ex_rs.push_back(r);  ex_nib.push_back(dat[3:0]);
    endtask

    task automatic check_pulses(input string tag, input int mark);
        chk({tag, "_npulses"}, p_rise.size() - mark, ex_nib.size());
        for (int i = 0; i < ex_nib.size() && mark + i < p_fall.size(); i++) begin
            chk({tag, "_nib"}, p_nib[mark + i], ex_nib[i]);
            chk({tag, "_rs"}, p_rs[mark + i], ex_rs[i]);
            chk({tag, "_width"}, p_fall[mark + i] - p_rise[mark + i], TP);
        end
        ex_nib.delete();
        ex_rs.delete();
    endtask

    // Releases reset (must be low on entry) and measures the init sequence.
    task automatic do_init(input bit noisy);
        int mark;
        int n;
        mark = p_rise.size();
        ex_rs = '{1'b0, 1'b0, 1'b0, 1'b0};
        ex_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        rst_n = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 300) begin
            if (noisy && n < 40) begin
                wr_valid = 1'b1;
                wr_rs    = 1'($urandom);
                wr_data  = 8'($urandom);
            end else begin
                wr_valid = 1'b0;
            end
            sync();
            n++;
        end
        wr_valid = 1'b0;
        chk("init_len", n, INIT_LEN);
        chk("init_done", init_done, 1);
        check_pulses("init", mark);
    endtask

    task automatic write_byte(input logic r, input logic [7:0] dat);
        int mark;
        int acc;
        int low;
        mark = p_rise.size();
        expect_byte(r, dat);
        chk("ready_before", wr_ready, 1);
        wr_valid = 1'b1;
        wr_rs    = r;
        wr_data  = dat;
        sync();
        acc      = ncnt;
        wr_valid = 1'b0;
        wr_rs    = 1'($urandom);
        wr_data  = 8'($urandom);
        low = 0;
        while (wr_ready !== 1'b1 && low < 200) begin
            low++;
            sync();
        end
        chk("occupancy", low, occupancy(r, dat));
        chk("setup_latency", (p_rise.size() > mark) ? p_rise[mark] - acc : -1, TS);
        chk("nibble_gap", (p_rise.size() > mark + 1) ? p_rise[mark + 1] - p_fall[mark] : -1,
            TH + TN + TS);
        check_pulses("byte", mark);
    endtask

    initial begin
        int mark;
        int nacc;
        int run;
        bit in_run;
        int runs[$];
        int occ_exp[$];
        logic r;
        logic [7:0] dat;
        int n;

        rst_n = 1'b0;
        repeat (3) sync();
        chk("rst_e", e, 0);
        chk("rst_rs", rs, 0);
        chk("rst_nib", {d, c, b, a}, 0);
        chk("rst_ready", wr_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_sf_e", sf_e, 1);
        chk("rst_rw", rw, 0);

        do_init(1'b0);

        write_byte(1'b1, 8'h41);
        write_byte(1'b0, 8'h01);
        write_byte(1'b1, 8'h01);
        write_byte(1'b0, 8'h02);
        write_byte(1'b0, 8'h38);
        repeat (6) begin
            r   = 1'($urandom);
            dat = 8'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : $urandom);
            write_byte(r, dat);
        end

        // wr_valid held high with changing data: one acceptance per IDLE visit.
        mark   = p_rise.size();
        nacc   = 0;
        run    = 0;
        in_run = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (wr_ready === 1'b1) begin
                if (in_run) begin
                    runs.push_back(run);
                    in_run = 1'b0;
                end
                if (nacc == 3) break;
                r   = 1'($urandom);
                dat = 8'($urandom_range(0, 2) == 0 ? $urandom_range(1, 2) : $urandom);
                if (nacc == 0) begin r = 1'b0; dat = 8'h01; end
                wr_valid = 1'b1;
                wr_rs    = r;
                wr_data  = dat;
                expect_byte(r, dat);
                occ_exp.push_back(occupancy(r, dat));
                nacc++;
            end else begin
                if (!in_run) begin
                    in_run = 1'b1;
                    run    = 0;
                end
                run++;
                wr_rs   = 1'($urandom);
                wr_data = 8'($urandom);
            end
            sync();
        end
        wr_valid = 1'b0;
        chk("hold_runs", runs.size(), 3);
        for (int i = 0; i < runs.size() && i < occ_exp.size(); i++)
            chk("hold_occupancy", runs[i], occ_exp[i]);
        check_pulses("hold", mark);
        sync();
        chk("hold_no_extra", wr_ready, 1);

        // Reset while e is high mid-byte.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h5A;
        sync();
        wr_valid = 1'b0;
        n = 0;
        while (e !== 1'b1 && n < 50) begin
            sync();
            n++;
        end
        chk("e_high_before_reset", e, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_e", e, 0);
        chk("midrst_ready", wr_ready, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_rs", rs, 0);
        chk("midrst_nib", {d, c, b, a}, 0);
        sync();
        sync();
        do_init(1'b1);
        write_byte(1'b1, 8'hA7);

        chk("const_sf_e_rw", bad_const, 0);
        chk("stable_while_e", bad_stab, 0);
        chk("setup_before_e", bad_setup, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
